// File: rtl/fifo_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared definitions for the FIFO-draining UART transmitter:
//   - FIFO_DATA_W    : byte width shared with the synchronous FIFO
//   - FRAME_BITS_8N1 : bits in one 8N1 frame (start + 8 data + stop)
//   - state_t        : transmitter FSM state encoding
//   - even_parity    : parity bit for the optional PARITY state
// ---------------------------------------------------------------------------
package fifo_uart_tx_pkg;

   localparam int FIFO_DATA_W    = 8;
   localparam int FRAME_BITS_8N1 = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_POP    = 3'd1,
      ST_LATCH  = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } state_t;

   // Even parity: the extra bit makes the total count of ones even.
   function automatic logic even_parity(input logic [FIFO_DATA_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// Groups the FIFO read port, the enable and the serial/status outputs of
// fifo_uart_tx.
//   master : environment side (drives tx_enable, fifo_empty, fifo_data)
//   slave  : transmitter side (drives fifo_rd_en, tx, busy, bytes_sent)
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) ();

   logic              tx_enable;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_rd_en;
   logic              tx;
   logic              busy;
   logic [CNT_W-1:0]  bytes_sent;

   modport master (
      output tx_enable, fifo_empty, fifo_data,
      input  fifo_rd_en, tx, busy, bytes_sent
   );

   modport slave (
      input  tx_enable, fifo_empty, fifo_data,
      output fifo_rd_en, tx, busy, bytes_sent
   );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear back to 0 (held while no bit is being timed)
//   tick  : high during the last cycle of a bit period
// ---------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear, wrap at the end of a bit, or advance.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == LAST) begin
         cnt_d = {CW{1'b0}};
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains the synchronous FIFO and sends every byte as a UART frame on tx,
// LSB first: start(0), 8 data bits, [even parity], stop(1).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fifo_uart_tx_if.slave
//            tx_enable  in  start new frames (looked at only when deciding
//                           whether to pop the next byte)
//            fifo_empty in  FIFO empty flag
//            fifo_data  in  FIFO read data, valid one cycle after fifo_rd_en
//            fifo_rd_en out one-cycle pop strobe per byte
//            tx         out serial line, idle high, registered
//            busy       out high in every state except IDLE
//            bytes_sent out completed-frame count, wraps
// Configuration macro: FIFO_UART_TX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
// ---------------------------------------------------------------------------
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int DATA_W       = FIFO_DATA_W,
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst,
   fifo_uart_tx_if.slave  bus
);

   localparam int               IDX_W        = $clog2(DATA_W);
   // Index of the final data bit of a frame.
   localparam logic [IDX_W-1:0] BIT_IDX_LAST = IDX_W'(FRAME_BITS_8N1 - 3);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    bytes_q, bytes_d;
   logic                rd_en_q, rd_en_d;
   logic                busy_q, busy_d;
   logic                tx_q, tx_d;
   logic                baud_clr_s;
   logic                tick_s;
   logic                can_pop_s;

   assign can_pop_s = bus.tx_enable && !bus.fifo_empty;

   // The bit timer only runs inside START/DATA/PARITY/STOP and restarts on
   // every state change.
   assign baud_clr_s = (state_d != state_q) || (state_q == ST_IDLE) ||
                       (state_q == ST_POP) || (state_q == ST_LATCH);

   baud_tick_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (baud_clr_s),
      .tick (tick_s)
   );

   // Next-state, datapath and registered-output values.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      bytes_d   = bytes_q;
      case (state_q)
         ST_IDLE: begin
            if (can_pop_s) begin
               state_d = ST_POP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_POP: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            // FIFO read data is valid now, one cycle after the pop strobe.
            shift_d   = bus.fifo_data;
            bit_idx_d = {IDX_W{1'b0}};
            state_d   = ST_START;
         end
         ST_START: begin
            if (tick_s) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               if (bit_idx_q == BIT_IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (tick_s) begin
               bytes_d = bytes_q + CNT_W'(1);
               // Back-to-back frames skip IDLE entirely.
               if (can_pop_s) begin
                  state_d = ST_POP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rd_en_d = (state_d == ST_POP);
      busy_d  = (state_d != ST_IDLE);

      // tx follows the current state one cycle later, from a flop.
      case (state_q)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_q[bit_idx_q];
`ifdef FIFO_UART_TX_PARITY_EN
         ST_PARITY: tx_d = even_parity(shift_q);
`endif
         default:   tx_d = 1'b1;
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         bit_idx_q <= {IDX_W{1'b0}};
         shift_q   <= {DATA_W{1'b0}};
         bytes_q   <= {CNT_W{1'b0}};
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         bytes_q   <= bytes_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         tx_q      <= tx_d;
      end
   end

   assign bus.fifo_rd_en = rd_en_q;
   assign bus.busy       = busy_q;
   assign bus.tx         = tx_q;
   assign bus.bytes_sent = bytes_q;

endmodule
